// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if -- port bundle for the multi-read / dual-write register file.
//
// Handshake: there is no valid/ready pair on this bundle. wr0_en_i, wr1_en_i
// and iss_en_i are single-cycle qualifiers that take effect at the next posedge
// only while ready_o is 1. With ready_o at 0 they are silently dropped, and the
// file never back-pressures. Reads are combinational and always accepted.
//
// Signals (direction as seen by the register file, modport slave):
//   rd_addr_i   NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data_o   NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy_o   NUM_RD         scoreboard busy for each addressed register
//   wr0_*       ALU writeback port (en/addr/data)
//   wr1_*       load writeback port (en/addr/data); wins over wr0 on the same address
//   iss_*       issue: mark a destination register busy
//   ready_o     clear engine finished, file usable
//   dbg_state_o FSM state (0 = INIT clear, 1 = RUN)
interface regfile_mp_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
   logic [NUM_RD*DATA_W-1:0] rd_data_o;
   logic [NUM_RD-1:0]        rd_busy_o;
   logic                     wr0_en_i;
   logic [ADDR_W-1:0]        wr0_addr_i;
   logic [DATA_W-1:0]        wr0_data_i;
   logic                     wr1_en_i;
   logic [ADDR_W-1:0]        wr1_addr_i;
   logic [DATA_W-1:0]        wr1_data_i;
   logic                     iss_en_i;
   logic [ADDR_W-1:0]        iss_addr_i;
   logic                     ready_o;
   logic                     dbg_state_o;

   modport master (
      output rd_addr_i, wr0_en_i, wr0_addr_i, wr0_data_i,
             wr1_en_i, wr1_addr_i, wr1_data_i, iss_en_i, iss_addr_i,
      input  rd_data_o, rd_busy_o, ready_o, dbg_state_o
   );

   modport slave (
      input  rd_addr_i, wr0_en_i, wr0_addr_i, wr0_data_i,
             wr1_en_i, wr1_addr_i, wr1_data_i, iss_en_i, iss_addr_i,
      output rd_data_o, rd_busy_o, ready_o, dbg_state_o
   );
endinterface

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb -- parametrised N-read / 2-write register file for the ID stage.
//
// After reset a clear engine zeroes one entry per cycle (INIT); ready_o rises
// on the DEPTH-th posedge after rst_i deasserts. In RUN, wr0 (ALU) and wr1
// (load) write independently; on the same address wr1 wins. Reads are
// combinational with write-through bypass (wr1 over wr0 over array).
// With ZERO_R0=1, entry 0 reads 0, is never written, bypassed or busy.
//
// Optional feature macro: REGFILE_SCOREBOARD_EN -- keeps one busy bit per
// entry, set by issue and cleared by writeback, reported on rd_busy_o.
// Without it rd_busy_o is 0 and the issue inputs are ignored.
//
// Ports:
//   clk_i   core clock, all state updates on posedge
//   rst_i   asynchronous, active-low reset
//   bus     regfile_mp_sb_if.slave (read ports, write ports, issue, ready_o, dbg_state_o)
module regfile_mp_sb #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_RD  = 2,
   parameter int ZERO_R0 = 1
) (
   input logic             clk_i,
   input logic             rst_i,
   regfile_mp_sb_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   clr_cnt;
   logic                ready_q;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                run;
   logic                we0, we1;
   logic [NUM_RD*DATA_W-1:0] rd_data_w;
   logic [NUM_RD-1:0]        rd_busy_w;

   assign run = (state == ST_RUN);
   // Qualified writes: only in RUN, and never to entry 0 when it is hard-wired.
   assign we0 = run && bus.wr0_en_i && !((ZERO_R0 != 0) && (bus.wr0_addr_i == '0));
   assign we1 = run && bus.wr1_en_i && !((ZERO_R0 != 0) && (bus.wr1_addr_i == '0));

   // Control FSM with registered ready.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= ST_INIT;
         clr_cnt <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               clr_cnt <= clr_cnt + ADDR_W'(1);
               if (&clr_cnt) begin
                  state   <= ST_RUN;
                  ready_q <= 1'b1;
               end
            end
            ST_RUN:  ready_q <= 1'b1;
            default: state   <= ST_INIT;
         endcase
      end
   end

   // Data array is deliberately not reset; the clear engine zeroes it instead.
   // wr1 is assigned last so it wins a same-address collision.
   always_ff @(posedge clk_i) begin
      if (state == ST_INIT) begin
         mem[clr_cnt] <= '0;
      end else begin
         if (we0) mem[bus.wr0_addr_i] <= bus.wr0_data_i;
         if (we1) mem[bus.wr1_addr_i] <= bus.wr1_data_i;
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [DEPTH-1:0] busy_q;

   // Clears first, set last: a same-cycle issue to a written register leaves
   // it busy because the new producer is still outstanding.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         busy_q <= '0;
      end else if (run) begin
         if (we0) busy_q[bus.wr0_addr_i] <= 1'b0;
         if (we1) busy_q[bus.wr1_addr_i] <= 1'b0;
         if (bus.iss_en_i && !((ZERO_R0 != 0) && (bus.iss_addr_i == '0)))
            busy_q[bus.iss_addr_i] <= 1'b1;
      end
   end
`else
   logic unused_iss;
   assign unused_iss = ^{bus.iss_en_i, bus.iss_addr_i};
`endif

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              zero_hit, hit0, hit1;
      logic [DATA_W-1:0] data;

      assign a        = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
      assign zero_hit = (ZERO_R0 != 0) && (a == '0);
      assign hit0     = we0 && (bus.wr0_addr_i == a);
      assign hit1     = we1 && (bus.wr1_addr_i == a);

      always_comb begin
         data = '0;
         if (run && !zero_hit) begin
            if (hit1)      data = bus.wr1_data_i;
            else if (hit0) data = bus.wr0_data_i;
            else           data = mem[a];
         end
      end

      assign rd_data_w[k*DATA_W +: DATA_W] = data;
`ifdef REGFILE_SCOREBOARD_EN
      // A writeback in flight to this register releases the hazard now,
      // in step with the data bypass.
      assign rd_busy_w[k] = run && !zero_hit && busy_q[a] && !hit0 && !hit1;
`else
      assign rd_busy_w[k] = 1'b0;
`endif
   end

   assign bus.rd_data_o   = rd_data_w;
   assign bus.rd_busy_o   = rd_busy_w;
   assign bus.ready_o     = ready_q;
   assign bus.dbg_state_o = state;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb -- directed bench for regfile_mp_sb.
// Instance dut_a uses ZERO_R0=1, dut_b uses ZERO_R0=0; both see identical stimulus.
module tb_regfile_mp_sb;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
`ifdef REGFILE_SCOREBOARD_EN
   localparam logic SB = 1'b1;
`else
   localparam logic SB = 1'b0;
`endif

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic          w0e, w1e, ie;
   logic [AW-1:0] w0a, w1a, ia, r0, r1;
   logic [DW-1:0] w0d, w1d;

   regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) ifa ();
   regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) ifb ();

   assign ifa.rd_addr_i = {r1, r0};
   assign ifa.wr0_en_i = w0e;  assign ifa.wr0_addr_i = w0a;  assign ifa.wr0_data_i = w0d;
   assign ifa.wr1_en_i = w1e;  assign ifa.wr1_addr_i = w1a;  assign ifa.wr1_data_i = w1d;
   assign ifa.iss_en_i = ie;   assign ifa.iss_addr_i = ia;
   assign ifb.rd_addr_i = {r1, r0};
   assign ifb.wr0_en_i = w0e;  assign ifb.wr0_addr_i = w0a;  assign ifb.wr0_data_i = w0d;
   assign ifb.wr1_en_i = w1e;  assign ifb.wr1_addr_i = w1a;  assign ifb.wr1_data_i = w1d;
   assign ifb.iss_en_i = ie;   assign ifb.iss_addr_i = ia;

   regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(1)) dut_a (
      .clk_i(clk_i), .rst_i(rst_i), .bus(ifa.slave));
   regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(0)) dut_b (
      .clk_i(clk_i), .rst_i(rst_i), .bus(ifb.slave));

   // clock / reset
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic w0e; logic [AW-1:0] w0a; logic [DW-1:0] w0d;
      logic w1e; logic [AW-1:0] w1a; logic [DW-1:0] w1d;
      logic ie;  logic [AW-1:0] ia;
      logic [AW-1:0] r0, r1;
      logic [DW-1:0] e0, e1;
      logic [NR-1:0] eb;
   } vec_t;

   vec_t vecs [12];

   // driver tasks
   task automatic drive(input logic a_w0e, input logic [AW-1:0] a_w0a, input logic [DW-1:0] a_w0d,
                        input logic a_w1e, input logic [AW-1:0] a_w1a, input logic [DW-1:0] a_w1d,
                        input logic a_ie,  input logic [AW-1:0] a_ia,
                        input logic [AW-1:0] a_r0, input logic [AW-1:0] a_r1);
      w0e = a_w0e; w0a = a_w0a; w0d = a_w0d;
      w1e = a_w1e; w1a = a_w1a; w1d = a_w1d;
      ie  = a_ie;  ia  = a_ia;
      r0  = a_r0;  r1  = a_r1;
   endtask

   task automatic idle(input logic [AW-1:0] a_r0, input logic [AW-1:0] a_r1);
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, a_r0, a_r1);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // scoreboard compare
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Runs the DEPTH-cycle clear after rst_i has just been released; INIT-time
   // stimulus (writes/issue to wa) must be ignored and reads must return 0.
   task automatic run_init(input string tag, input logic [AW-1:0] wa);
      drive(1'b1, wa, 32'h0000_1234, 1'b1, wa, 32'h0000_5678, 1'b1, wa, wa, wa);
      for (int c = 1; c <= 32; c++) begin
         tick();
         chk($sformatf("%s_ready_c%0d", tag, c), {63'd0, ifa.ready_o}, {63'd0, (c == 32)});
         if (c == 31 || c == 32)
            chk($sformatf("%s_state_c%0d", tag, c), {63'd0, ifa.dbg_state_o}, {63'd0, (c == 32)});
         if (c < 32) begin
            chk($sformatf("%s_rd_init_c%0d", tag, c), {32'd0, ifa.rd_data_o[31:0]}, 64'd0);
            chk($sformatf("%s_busy_init_c%0d", tag, c), {62'd0, ifa.rd_busy_o}, 64'd0);
         end
      end
      idle(wa, 5'd0);
      #1;
      chk({tag, "_rd_after_init_p0"}, {32'd0, ifa.rd_data_o[31:0]}, 64'd0);
      chk({tag, "_rd_after_init_p1"}, {32'd0, ifa.rd_data_o[63:32]}, 64'd0);
      chk({tag, "_busy_after_init"}, {62'd0, ifa.rd_busy_o}, 64'd0);
      chk({tag, "_b_x0_after_init"}, {32'd0, ifb.rd_data_o[63:32]}, 64'd0);
   endtask

   initial begin
      // w0e w0a w0d            w1e w1a w1d            ie  ia   r0  r1   e0             e1             eb
      vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
      vecs[2]  = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  32'h22,       1'b0, 5'd0, 5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 2'b00};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd7,  32'h22,       32'h22,       2'b00};
      vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd7,  32'h0,        32'h22,       2'b00};
      vecs[6]  = '{1'b1, 5'd13, 32'h01234567, 1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 5'd0, 5'd12, 5'd13, 32'hCAFEF00D, 32'h01234567, 2'b00};
      vecs[7]  = '{1'b1, 5'd12, 32'hAAAA5555, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd12, 5'd13, 32'hAAAA5555, 32'h01234567, 2'b00};
      vecs[8]  = '{1'b1, 5'd31, 32'h80000001, 1'b1, 5'd1,  32'h7,        1'b0, 5'd0, 5'd31, 5'd1,  32'h80000001, 32'h7,        2'b00};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd31, 5'd1,  32'h80000001, 32'h7,        2'b00};
      vecs[10] = '{1'b1, 5'd12, 32'h1,        1'b1, 5'd13, 32'h2,        1'b0, 5'd0, 5'd13, 5'd12, 32'h2,        32'h1,        2'b00};
      vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h3,        1'b0, 5'd0, 5'd12, 5'd13, 32'h3,        32'h2,        2'b00};

      // reset state
      idle(5'd5, 5'd5);
      #1;
      chk("reset_ready", {63'd0, ifa.ready_o}, 64'd0);
      chk("reset_state", {63'd0, ifa.dbg_state_o}, 64'd0);
      chk("reset_rd", {32'd0, ifa.rd_data_o[31:0]}, 64'd0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      run_init("init1", 5'd5);

      // table-driven RUN vectors
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].w0e, vecs[i].w0a, vecs[i].w0d, vecs[i].w1e, vecs[i].w1a, vecs[i].w1d,
               vecs[i].ie, vecs[i].ia, vecs[i].r0, vecs[i].r1);
         #1;
         chk($sformatf("vec%0d_rd0", i), {32'd0, ifa.rd_data_o[31:0]}, {32'd0, vecs[i].e0});
         chk($sformatf("vec%0d_rd1", i), {32'd0, ifa.rd_data_o[63:32]}, {32'd0, vecs[i].e1});
         chk($sformatf("vec%0d_busy", i), {62'd0, ifa.rd_busy_o}, {62'd0, vecs[i].eb});
         tick();
      end

      // entry 0: hard-wired in dut_a, ordinary in dut_b
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
      #1;
      chk("z0_a_rd_bypass", {32'd0, ifa.rd_data_o[31:0]}, 64'd0);
      chk("z0_a_busy", {62'd0, ifa.rd_busy_o}, 64'd0);
      chk("z0_b_rd_bypass", {32'd0, ifb.rd_data_o[31:0]}, {32'd0, 32'hFFFFFFFF});
      tick();
      idle(5'd0, 5'd0);
      #1;
      chk("z0_a_rd_array", {32'd0, ifa.rd_data_o[31:0]}, 64'd0);
      chk("z0_a_busy_after", {62'd0, ifa.rd_busy_o}, 64'd0);
      chk("z0_b_rd_array", {32'd0, ifb.rd_data_o[31:0]}, {32'd0, 32'hFFFFFFFF});
      chk("z0_b_busy_after", {63'd0, ifb.rd_busy_o[0]}, {63'd0, SB});
      tick();

      // scoreboard sequence on x9
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
      #1;
      chk("sb_iss_same_cycle_busy", {62'd0, ifa.rd_busy_o}, 64'd0);
      tick();
      idle(5'd9, 5'd9);
      #1;
      chk("sb_busy_after_iss", {62'd0, ifa.rd_busy_o}, {62'd0, SB, SB});
      tick();
      drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h42, 1'b0, '0, 5'd9, 5'd9);
      #1;
      chk("sb_wb_release_busy", {62'd0, ifa.rd_busy_o}, 64'd0);
      chk("sb_wb_bypass_data", {32'd0, ifa.rd_data_o[63:32]}, 64'h42);
      tick();
      idle(5'd9, 5'd9);
      #1;
      chk("sb_cleared_busy", {62'd0, ifa.rd_busy_o}, 64'd0);
      chk("sb_cleared_data", {32'd0, ifa.rd_data_o[31:0]}, 64'h42);
      tick();
      drive(1'b1, 5'd9, 32'h55, 1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
      #1;
      chk("sb_iss_wr_same_busy", {62'd0, ifa.rd_busy_o}, 64'd0);
      chk("sb_iss_wr_same_data", {32'd0, ifa.rd_data_o[31:0]}, 64'h55);
      tick();
      idle(5'd9, 5'd9);
      #1;
      chk("sb_set_wins_busy", {62'd0, ifa.rd_busy_o}, {62'd0, SB, SB});
      chk("sb_set_wins_data", {32'd0, ifa.rd_data_o[63:32]}, 64'h55);
      tick();

      // reset mid-RUN with x3 busy
      drive(1'b1, 5'd3, 32'h33, 1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd9);
      #1;
      tick();
      idle(5'd3, 5'd9);
      #1;
      chk("mid_x3_data", {32'd0, ifa.rd_data_o[31:0]}, 64'h33);
      chk("mid_x3_busy", {62'd0, ifa.rd_busy_o}, {62'd0, SB, SB});
      rst_i = 1'b0;
      #1;
      chk("mid_rst_ready", {63'd0, ifa.ready_o}, 64'd0);
      chk("mid_rst_state", {63'd0, ifa.dbg_state_o}, 64'd0);
      chk("mid_rst_rd", {32'd0, ifa.rd_data_o[31:0]}, 64'd0);
      chk("mid_rst_busy", {62'd0, ifa.rd_busy_o}, 64'd0);
      tick();
      tick();
      rst_i = 1'b1;
      run_init("init2", 5'd3);
      idle(5'd3, 5'd9);
      #1;
      chk("reinit_x3_data", {32'd0, ifa.rd_data_o[31:0]}, 64'd0);
      chk("reinit_x9_data", {32'd0, ifa.rd_data_o[63:32]}, 64'd0);
      chk("reinit_busy", {62'd0, ifa.rd_busy_o}, 64'd0);

      // final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
